// File: rtl/display_pkg.sv
// display_pkg: active-low seven-segment glyphs and segment bit positions shared by RTL and benches.
package display_pkg;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam logic [6:0] SEG_0 = 7'b100_0000;
    localparam logic [6:0] SEG_1 = 7'b111_1001;
    localparam logic [6:0] SEG_2 = 7'b010_0100;
    localparam logic [6:0] SEG_3 = 7'b011_0000;
    localparam logic [6:0] SEG_4 = 7'b001_1001;
    localparam logic [6:0] SEG_5 = 7'b001_0010;
    localparam logic [6:0] SEG_6 = 7'b000_0010;
    localparam logic [6:0] SEG_7 = 7'b111_1000;
    localparam logic [6:0] SEG_8 = 7'b000_0000;
    localparam logic [6:0] SEG_9 = 7'b001_1000;
    localparam logic [6:0] SEG_INVALID = 7'b000_0000;
endpackage

// File: rtl/binary_to_seven_seg_gl_decoder.sv
// decoder_4to16_gl: one-hot minterm decoder of a 4-bit value built from AND/OR/NOT terms.
module decoder_4to16_gl (
    input  logic [3:0]  in,
    output logic [15:0] minterm
);
    for (genvar i = 0; i < 16; i++) begin : g_m
        localparam logic [3:0] CODE = 4'(i);
        logic [3:0] lit;
        // Each literal is in[b] or ~in[b] depending on the code bit; constants fold away.
        assign lit = (in & CODE) | (~in & ~CODE);
        assign minterm[i] = &lit;
    end
endmodule

// File: rtl/binary_to_seven_seg_gl.sv
// binary_to_seven_seg_gl: gate-level 4-bit to active-low seven-segment decoder.
// Each segment output is the OR of the minterms where that segment is dark; codes 10-15 light everything.
module binary_to_seven_seg_gl
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in,
    output logic [6:0] seg
);
    logic [15:0] m;
    logic        unused_ok;
    decoder_4to16_gl u_dec (
        .in      (in),
        .minterm (m)
    );
    assign seg[SEG_A] = m[1] | m[4];
    assign seg[SEG_B] = m[5] | m[6];
    assign seg[SEG_C] = m[2];
    assign seg[SEG_D] = m[1] | m[4] | m[7] | m[9];
    assign seg[SEG_E] = m[1] | m[3] | m[4] | m[5] | m[7] | m[9];
    assign seg[SEG_F] = m[1] | m[2] | m[3] | m[7];
    assign seg[SEG_G] = m[0] | m[1] | m[7];
    // clk/reset exist only for the port convention; 8 and 10-15 darken no segment.
    assign unused_ok = &{1'b0, clk, reset, m[8], m[15:10]};
endmodule

// File: tb/tb_binary_to_seven_seg_gl.sv
// tb_binary_to_seven_seg_gl: scoreboard bench comparing the decoder against a lit-segment glyph model.
module tb_binary_to_seven_seg_gl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in = 4'd0;
    logic [6:0] seg;
    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] exp_q[$];
    logic [3:0] code_q[$];
    string      glyph[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                              "acdfg", "acdefg", "abc", "abcdefg", "abcfg"};

    binary_to_seven_seg_gl dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    // Start all dark, then clear the bit of every lit segment letter.
    function automatic logic [6:0] model(input logic [3:0] v);
        logic [6:0] r = 7'h7f;
        string s;
        if (v > 4'd9) return 7'h00;
        s = glyph[v];
        for (int k = 0; k < s.len(); k++) r[int'(s[k]) - 97] = 1'b0;
        return r;
    endfunction

    task automatic apply(input logic r, input logic [3:0] v);
        @(posedge clk);
        #1;
        reset = r;
        in = v;
        exp_q.push_back(model(v));
        code_q.push_back(v);
        vectors++;
    endtask

    // Sample one time unit before the next rising edge.
    initial begin
        logic [6:0] e;
        logic [3:0] c;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = code_q.pop_front();
                if (seg !== e) begin
                    miscompares++;
                    $display("FAIL seg in=%0d reset=%0b: got %b expected %b", c, reset, seg, e);
                end
            end
        end
    end

    initial begin
        apply(1'b0, 4'd0);
        apply(1'b0, 4'd1);
        apply(1'b0, 4'd7);
        apply(1'b0, 4'd15);
        for (int i = 0; i < 16; i++) apply(1'b0, 4'(i));
        apply(1'b1, 4'd3);
        apply(1'b1, 4'd3);
        apply(1'b0, 4'd3);
        apply(1'b0, 4'd8);
        apply(1'b0, 4'd1);
        apply(1'b0, 4'd8);
        for (int i = 0; i < 60; i++) apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
